// File: rtl/lc_pkg.sv
// lc_pkg: shared FSM encoding, increment steps and default width for the location counter.
package lc_pkg;
  localparam int LC_WIDTH_DEF = 26;
  localparam logic [1:0] INC_BYTE = 2'd1;
  localparam logic [1:0] INC_HALF = 2'd2;
  typedef enum logic [1:0] {
    ST_VALID = 2'b00,
    ST_NEED  = 2'b01,
    ST_REQ   = 2'b10
  } lc_state_e;
endpackage

// File: rtl/lc_fetch_fsm.sv
// lc_fetch_fsm: word-present tracking and fetch request/acknowledge handshake.
module lc_fetch_fsm
  import lc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic word_change_i,
  input  logic load_i,
  input  logic inc_i,
  input  logic fetch_ack_i,
  output logic valid_o,
  output logic need_fetch_o,
  output logic fetch_req_o,
  output logic stall_o
);
  lc_state_e state_q, state_d;
  always_ff @(posedge clk) begin
    state_q <= rst ? ST_NEED : state_d;
  end
  // A load while requesting abandons the in-flight word, so any same-cycle ack is stale.
  always_comb begin
    state_d = (state_q == ST_VALID) ? ((load_i | word_change_i) ? ST_NEED : ST_VALID)
            : (state_q == ST_NEED)  ? ST_REQ
            : load_i                ? ST_NEED
            : fetch_ack_i           ? ST_VALID
            :                         ST_REQ;
  end
  always_comb begin
    valid_o      = state_q == ST_VALID;
    need_fetch_o = state_q != ST_VALID;
    fetch_req_o  = state_q == ST_REQ;
    stall_o      = inc_i & (state_q != ST_VALID);
  end
endmodule

// File: rtl/lc_counter.sv
// lc_counter: byte-address location counter with word-fetch handshake.
// Define LC_PARITY_EN to add the registered odd-parity output LC_PAR.
module lc_counter
  import lc_pkg::*;
#(
  parameter int               WIDTH    = LC_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_LC = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LD,
  input  logic [WIDTH-1:0] LD_DATA,
  input  logic             INC,
  input  logic             BYTE_MODE,
  input  logic             FETCH_ACK,
  output logic [WIDTH-1:0] LC,
  output logic [WIDTH-3:0] LC_WORD,
  output logic             NEED_FETCH,
  output logic             FETCH_REQ,
  output logic             STALL,
  output logic             CARRY_OUT
`ifdef LC_PARITY_EN
  , output logic           LC_PAR
`endif
);
  logic [WIDTH-1:0] lc_q, lc_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   sum;
  logic             valid, inc_go, word_change;
  assign sum         = {1'b0, lc_q} + {{(WIDTH-1){1'b0}}, (BYTE_MODE ? INC_BYTE : INC_HALF)};
  assign inc_go      = INC & ~LD & valid;
  assign word_change = inc_go & (sum[WIDTH-1:2] != lc_q[WIDTH-1:2]);
  always_comb begin
    lc_d    = LD ? LD_DATA : inc_go ? sum[WIDTH-1:0] : lc_q;
    carry_d = inc_go & sum[WIDTH];
  end
  always_ff @(posedge CLK) begin
    lc_q    <= RESET ? RESET_LC : lc_d;
    carry_q <= ~RESET & carry_d;
  end
  assign LC        = lc_q;
  assign LC_WORD   = lc_q[WIDTH-1:2];
  assign CARRY_OUT = carry_q;
`ifdef LC_PARITY_EN
  logic par_q;
  always_ff @(posedge CLK) begin
    par_q <= RESET ? ~^RESET_LC : ~^lc_d;
  end
  assign LC_PAR = par_q;
`endif
  lc_fetch_fsm u_fsm (
    .clk          (CLK),
    .rst          (RESET),
    .word_change_i(word_change),
    .load_i       (LD),
    .inc_i        (INC),
    .fetch_ack_i  (FETCH_ACK),
    .valid_o      (valid),
    .need_fetch_o (NEED_FETCH),
    .fetch_req_o  (FETCH_REQ),
    .stall_o      (STALL)
  );
endmodule

// File: tb/tb_lc_counter.sv
// tb_lc_counter: directed self-checking bench for lc_counter.
module tb_lc_counter;
  localparam int W = 26;
  logic CLK = 1'b0;
  logic RESET, LD, INC, BYTE_MODE, FETCH_ACK;
  logic [W-1:0] LD_DATA, LC;
  logic [W-3:0] LC_WORD;
  logic NEED_FETCH, FETCH_REQ, STALL, CARRY_OUT;
`ifdef LC_PARITY_EN
  logic LC_PAR;
`endif
  int checks = 0;
  int errors = 0;

  lc_counter #(.WIDTH(W), .RESET_LC('0)) dut (
    .CLK(CLK), .RESET(RESET), .LD(LD), .LD_DATA(LD_DATA), .INC(INC),
    .BYTE_MODE(BYTE_MODE), .FETCH_ACK(FETCH_ACK), .LC(LC), .LC_WORD(LC_WORD),
    .NEED_FETCH(NEED_FETCH), .FETCH_REQ(FETCH_REQ), .STALL(STALL), .CARRY_OUT(CARRY_OUT)
`ifdef LC_PARITY_EN
    , .LC_PAR(LC_PAR)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack();
    FETCH_ACK = 1'b1;
    tick();
    FETCH_ACK = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] v);
    LD = 1'b1;
    LD_DATA = v;
    tick();
    LD = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; LD = 1'b0; INC = 1'b0; BYTE_MODE = 1'b1; FETCH_ACK = 1'b0; LD_DATA = '0;
    tick();
    tick();
    RESET = 1'b0;
    chk("rst_lc", LC, 32'h0);
    chk("rst_need", NEED_FETCH, 1);
    chk("rst_req", FETCH_REQ, 0);
    chk("rst_carry", CARRY_OUT, 0);
    chk("rst_stall", STALL, 0);
`ifdef LC_PARITY_EN
    chk("rst_par", LC_PAR, 1);
`endif
    tick();
    chk("req_after_rst", FETCH_REQ, 1);
    tick();
    chk("req_held", FETCH_REQ, 1);
    ack();
    chk("ack_need", NEED_FETCH, 0);
    chk("ack_req", FETCH_REQ, 0);

    load(26'h100);
    chk("ld_lc", LC, 32'h100);
    chk("ld_need", NEED_FETCH, 1);
    chk("ld_req0", FETCH_REQ, 0);
    tick();
    chk("ld_req1", FETCH_REQ, 1);
    ack();
    INC = 1'b1;
    tick();
    chk("byte1_lc", LC, 32'h101);
    chk("byte1_need", NEED_FETCH, 0);
    tick();
    chk("byte2_lc", LC, 32'h102);
    tick();
    chk("byte3_lc", LC, 32'h103);
    chk("byte3_need", NEED_FETCH, 0);
    chk("byte3_word", LC_WORD, 32'h40);
    tick();
    INC = 1'b0;
    chk("byte4_lc", LC, 32'h104);
    chk("byte4_word", LC_WORD, 32'h41);
    chk("byte4_need", NEED_FETCH, 1);
    chk("byte4_req0", FETCH_REQ, 0);
    tick();
    chk("byte4_req1", FETCH_REQ, 1);
    ack();

    load(26'h2);
    tick();
    ack();
    BYTE_MODE = 1'b0;
    INC = 1'b1;
    tick();
    chk("half_lc", LC, 32'h4);
    chk("half_need", NEED_FETCH, 1);
    chk("half_stall_need", STALL, 1);
    tick();
    chk("stall_lc", LC, 32'h4);
    chk("stall_req", FETCH_REQ, 1);
    chk("stall_on", STALL, 1);
    INC = 1'b0;
    #1;
    chk("stall_off", STALL, 0);
    ack();

    load(26'h105);
    tick();
    ack();
    INC = 1'b1;
    tick();
    INC = 1'b0;
    chk("odd_half_lc", LC, 32'h107);
    chk("odd_half_need", NEED_FETCH, 0);

    load(26'h3FFFFFF);
    tick();
    ack();
    BYTE_MODE = 1'b1;
    INC = 1'b1;
    tick();
    INC = 1'b0;
    chk("wrap_lc", LC, 32'h0);
    chk("wrap_carry", CARRY_OUT, 1);
    chk("wrap_need", NEED_FETCH, 1);
    tick();
    chk("wrap_carry_off", CARRY_OUT, 0);
    ack();

    LD = 1'b1; INC = 1'b1; LD_DATA = 26'h200;
    tick();
    LD = 1'b0; INC = 1'b0;
    chk("ldinc_lc", LC, 32'h200);
    chk("ldinc_need", NEED_FETCH, 1);
    tick();
    chk("ldinc_req", FETCH_REQ, 1);
    LD = 1'b1; LD_DATA = 26'h300; FETCH_ACK = 1'b1;
    tick();
    LD = 1'b0; FETCH_ACK = 1'b0;
    chk("ldack_lc", LC, 32'h300);
    chk("ldack_need", NEED_FETCH, 1);
    chk("ldack_req_drop", FETCH_REQ, 0);
    tick();
    chk("ldack_req_back", FETCH_REQ, 1);

    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rstreq_lc", LC, 32'h0);
    chk("rstreq_req", FETCH_REQ, 0);
    chk("rstreq_need", NEED_FETCH, 1);
    tick();
    RESET = 1'b1; FETCH_ACK = 1'b1;
    tick();
    RESET = 1'b0; FETCH_ACK = 1'b0;
    chk("rstack_need", NEED_FETCH, 1);
    chk("rstack_req", FETCH_REQ, 0);

`ifdef LC_PARITY_EN
    load(26'h7);
    chk("par7", LC_PAR, 0);
    load(26'h3);
    chk("par3", LC_PAR, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
